rr_req_arbiter4: RTL and testbench
==================================

// Module: rr_req_arbiter4
// PURPOSE
//  - Four-requester round-robin arbiter; the stage directly upstream of the 2-to-4 one-hot decoder.
//  - gnt_idx drives the decoder's 2-bit select; gnt_valid qualifies the decoded one-hot output.
//  - Holds each grant until release, request drop or optional timeout, then rotates priority.
// PARAMETERS
//  - TIMEOUT  16  max cycles in GRANT before forced release (only with RR_TIMEOUT_EN); legal 2..2^CNT_W
//  - CNT_W    5   width of the hold counter
// PORTS
//  - clk        in   1  single clock, rising edge
//  - rst        in   1  reset, asynchronous, active-high
//  - req        in   4  request vector, bit i = requester i
//  - done       in   1  one-cycle pulse from the current owner releasing the grant
//  - gnt_idx    out  2  granted requester index (to decoder select)
//  - gnt_valid  out  1  gnt_idx is a live grant
//  - timeout    out  1  one-cycle pulse on forced release (0 without RR_TIMEOUT_EN)
// BEHAVIOUR
//  - Reset (async, no clock needed):
//    - state=IDLE, ptr=0, gnt_idx=0, gnt_valid=0, timeout=0, hold counter=0.
//  - All outputs registered.
//  - FSM IDLE:
//    - if |req, pick first set bit scanning ptr, ptr+1, ptr+2, ptr+3 (mod 4).
//    - Load gnt_idx, set gnt_valid, go to GRANT; else stay.
//    - Latency: req seen at edge N -> gnt_valid=1 after edge N.
//  - FSM GRANT:
//    - gnt_idx stable; other requests ignored.
//    - Release when any of: done=1, req[gnt_idx]=0, timeout reached.
//    - On release edge: gnt_valid=0, ptr=gnt_idx+1 (3 wraps to 0), go to IDLE.
//  - Minimum one cycle of gnt_valid=0 between consecutive grants (decoder never sees back-to-back select change while valid).
//  - gnt_idx holds last granted value while gnt_valid=0; consumers must qualify with gnt_valid.
//  - done in IDLE ignored.
//  - done and req drop in the same cycle = single release.
//  - Timeout in the same cycle as done: release counts as normal, timeout stays 0.
//  - Reset mid-GRANT: immediate return to reset values; the in-flight grant is lost, ptr back to 0.
// CONFIGURATION
//  - Macro RR_TIMEOUT_EN.
//  - Defined:
//    - hold counter clears on entering GRANT, increments each GRANT cycle.
//    - When counter==TIMEOUT-1 and no other release: forced release, timeout=1 for exactly that one cycle after the edge.
//    - Counter saturates, never wraps.
//  - Undefined:
//    - no counter logic; timeout tied 0.
//    - Grant held until done or req drop, indefinitely.
// TESTING
//  - rst=1 with req=4'hF, no clock -> gnt_valid=0, gnt_idx=0, timeout=0 immediately.
//  - After reset req=4'b1010 -> gnt_idx=1, gnt_valid=1 after 1 edge; done pulse -> idle cycle, then gnt_idx=3.
//  - req=4'hF held, done pulsed 1 cycle after each grant -> gnt_idx sequence 0,1,2,3,0, valid low 1 cycle between each.
//  - Only req[2] held, no done:
//    - with RR_TIMEOUT_EN, TIMEOUT=16 -> release after 16 GRANT cycles, timeout pulse 1 cycle, re-grant 2 after idle cycle.
//    - without the macro -> grant held for 100+ cycles, timeout=0.
//  - Grant to 1, drop req[1] -> gnt_valid=0 after next edge; ptr=2, so req=4'b0101 then grants 2.
//  - Async rst pulse mid-GRANT between edges -> outputs clear at once; after release req=4'b1001 grants 0.

Source files
------------

// File: rtl/rr_req_arbiter4.sv
// -----------------------------------------------------------------------------
// rr_req_arbiter4
// Four-requester round-robin arbiter that feeds the select of a 2-to-4
// one-hot decoder. A grant is held until the owner pulses done, drops its
// request or (optionally) the hold timer expires. Priority then rotates to
// the requester after the released one.
//
// Optional feature macro: RR_TIMEOUT_EN
//   defined   -> hold counter forces release after TIMEOUT cycles in GRANT
//   undefined -> no counter, timeout output tied low
//
// Parameters
//   TIMEOUT   max cycles in GRANT before forced release (2..2^CNT_W)
//   CNT_W     hold counter width
//
// Ports
//   clk        in   rising-edge clock
//   rst        in   asynchronous active-high reset
//   req[3:0]   in   request vector, bit i = requester i
//   done       in   one-cycle release pulse from the current owner
//   gnt_idx    out  granted requester index (decoder select), registered
//   gnt_valid  out  gnt_idx is a live grant, registered
//   timeout    out  one-cycle pulse after a forced release, registered
// -----------------------------------------------------------------------------
module rr_req_arbiter4 #(
    parameter int TIMEOUT = 16,
    parameter int CNT_W   = 5
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [3:0] req,
    input  logic       done,
    output logic [1:0] gnt_idx,
    output logic       gnt_valid,
    output logic       timeout
);

    localparam logic [0:0] ST_IDLE  = 1'b0;
    localparam logic [0:0] ST_GRANT = 1'b1;

    // Reject illegal timer configurations at elaboration.
    if ((TIMEOUT < 2) || (TIMEOUT > (1 << CNT_W))) begin : g_bad_cfg
        $error("rr_req_arbiter4: TIMEOUT out of range for CNT_W");
    end

    // Round-robin pick: returns {found, index}; lowest offset from p wins.
    function automatic logic [2:0] rr_pick(input logic [3:0] r, input logic [1:0] p);
        logic [2:0] res;
        logic [1:0] cand;
        res = 3'b000;
        for (int i = 3; i >= 0; i--) begin
            cand = p + 2'(i);
            if (r[cand]) begin
                res = {1'b1, cand};
            end
        end
        return res;
    endfunction

    logic [0:0] state_r;
    logic [0:0] state_nxt_s;
    logic [1:0] ptr_r;
    logic [1:0] ptr_nxt_s;
    logic [1:0] idx_nxt_s;
    logic       valid_nxt_s;
    logic       tmo_nxt_s;
    logic [2:0] pick_s;
    logic       tmo_hit_s;
    logic       norm_rel_s;

    assign pick_s = rr_pick(req, ptr_r);

    // Normal release: owner signals done or withdraws its request.
    assign norm_rel_s = done | ~req[gnt_idx];

`ifdef RR_TIMEOUT_EN
    logic [CNT_W-1:0] cnt_r;
    logic [CNT_W-1:0] cnt_nxt_s;

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);
    localparam logic [CNT_W-1:0] CNT_MAX  = {CNT_W{1'b1}};

    assign tmo_hit_s = (state_r == ST_GRANT) && (cnt_r == CNT_LAST);

    // Hold counter: cleared on grant, saturating increment while granted.
    always_comb begin
        cnt_nxt_s = cnt_r;
        if (state_r == ST_IDLE) begin
            cnt_nxt_s = {CNT_W{1'b0}};
        end else if (cnt_r != CNT_MAX) begin
            cnt_nxt_s = cnt_r + {{(CNT_W-1){1'b0}}, 1'b1};
        end else begin
            cnt_nxt_s = cnt_r;
        end
    end

    // Hold counter register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_r <= {CNT_W{1'b0}};
        end else begin
            cnt_r <= cnt_nxt_s;
        end
    end
`else
    assign tmo_hit_s = 1'b0;
`endif

    // Next-state logic for FSM, pointer and registered outputs.
    always_comb begin
        state_nxt_s = state_r;
        ptr_nxt_s   = ptr_r;
        idx_nxt_s   = gnt_idx;
        valid_nxt_s = gnt_valid;
        tmo_nxt_s   = 1'b0;
        case (state_r)
            ST_IDLE: begin
                if (pick_s[2]) begin
                    idx_nxt_s   = pick_s[1:0];
                    valid_nxt_s = 1'b1;
                    state_nxt_s = ST_GRANT;
                end else begin
                    valid_nxt_s = 1'b0;
                end
            end
            ST_GRANT: begin
                if (norm_rel_s || tmo_hit_s) begin
                    valid_nxt_s = 1'b0;
                    ptr_nxt_s   = gnt_idx + 2'd1;
                    state_nxt_s = ST_IDLE;
                    // A normal release in the same cycle masks the timeout.
                    tmo_nxt_s   = ~norm_rel_s;
                end else begin
                    valid_nxt_s = 1'b1;
                end
            end
            default: begin
                state_nxt_s = ST_IDLE;
                valid_nxt_s = 1'b0;
            end
        endcase
    end

    // State, pointer and output registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r   <= ST_IDLE;
            ptr_r     <= 2'd0;
            gnt_idx   <= 2'd0;
            gnt_valid <= 1'b0;
            timeout   <= 1'b0;
        end else begin
            state_r   <= state_nxt_s;
            ptr_r     <= ptr_nxt_s;
            gnt_idx   <= idx_nxt_s;
            gnt_valid <= valid_nxt_s;
            timeout   <= tmo_nxt_s;
        end
    end

endmodule

// File: tb/tb_rr_req_arbiter4.sv
module tb_rr_req_arbiter4;

    logic       clk;
    logic       rst;
    logic [3:0] req;
    logic       done;
    logic [1:0] gnt_idx;
    logic       gnt_valid;
    logic       timeout;

    int n_cmp;
    int n_err;

    rr_req_arbiter4 #(.TIMEOUT(16), .CNT_W(5)) dut (
        .clk       (clk),
        .rst       (rst),
        .req       (req),
        .done      (done),
        .gnt_idx   (gnt_idx),
        .gnt_valid (gnt_valid),
        .timeout   (timeout)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic chk_out(input string tag, input logic v, input logic [1:0] idx, input logic t);
        chk({tag, ".valid"}, {31'd0, gnt_valid}, {31'd0, v});
        chk({tag, ".idx"}, {30'd0, gnt_idx}, {30'd0, idx});
        chk({tag, ".timeout"}, {31'd0, timeout}, {31'd0, t});
    endtask

    logic [1:0] seq [5];

    initial begin
        n_cmp = 0;
        n_err = 0;
        seq[0] = 2'd0; seq[1] = 2'd1; seq[2] = 2'd2; seq[3] = 2'd3; seq[4] = 2'd0;

        // Async reset with requests pending, before any clock edge.
        rst  = 1'b0;
        req  = 4'hF;
        done = 1'b0;
        #1 rst = 1'b1;
        #1 chk_out("reset_noclk", 1'b0, 2'd0, 1'b0);
        tick();
        tick();
        chk_out("reset_clk", 1'b0, 2'd0, 1'b0);
        req = 4'h0;
        rst = 1'b0;
        tick();
        chk_out("idle_noreq", 1'b0, 2'd0, 1'b0);

        // req=1010 grants 1, done releases, then 3.
        req = 4'b1010;
        tick();
        chk_out("g1010_a", 1'b1, 2'd1, 1'b0);
        done = 1'b1;
        tick();
        done = 1'b0;
        chk_out("g1010_rel", 1'b0, 2'd1, 1'b0);
        tick();
        chk_out("g1010_b", 1'b1, 2'd3, 1'b0);
        req = 4'h0;
        tick();
        chk_out("g1010_drop", 1'b0, 2'd3, 1'b0);

        // All requesting: rotation 0,1,2,3,0 with one idle cycle between.
        req = 4'hF;
        for (int k = 0; k < 5; k++) begin
            tick();
            chk_out("rot_grant", 1'b1, seq[k], 1'b0);
            done = 1'b1;
            tick();
            done = 1'b0;
            chk_out("rot_gap", 1'b0, seq[k], 1'b0);
        end
        req = 4'h0;
        tick();
        chk_out("rot_end", 1'b0, 2'd0, 1'b0);

        // Grant 1, drop its request; ptr moves to 2.
        req = 4'b0010;
        tick();
        chk_out("drop_g", 1'b1, 2'd1, 1'b0);
        req = 4'b0000;
        tick();
        chk_out("drop_rel", 1'b0, 2'd1, 1'b0);
        req = 4'b0101;
        tick();
        chk_out("drop_next", 1'b1, 2'd2, 1'b0);
        req = 4'h0;
        tick();
        chk_out("drop_idle", 1'b0, 2'd2, 1'b0);

        // Only req[2] held, no done.
        req = 4'b0100;
        tick();
        chk_out("hold_g", 1'b1, 2'd2, 1'b0);
`ifdef RR_TIMEOUT_EN
        for (int k = 0; k < 15; k++) begin
            tick();
            chk_out("hold_cnt", 1'b1, 2'd2, 1'b0);
        end
        tick();
        chk_out("tmo_pulse", 1'b0, 2'd2, 1'b1);
        tick();
        chk_out("tmo_regrant", 1'b1, 2'd2, 1'b0);
`else
        for (int k = 0; k < 110; k++) begin
            tick();
            chk_out("hold_long", 1'b1, 2'd2, 1'b0);
        end
`endif
        req = 4'h0;
        tick();
        chk_out("hold_rel", 1'b0, 2'd2, 1'b0);

        // Async reset mid-GRANT, then ptr restarts at 0.
        req = 4'b1001;
        tick();
        chk_out("rst_g", 1'b1, 2'd3, 1'b0);
        #2 rst = 1'b1;
        #1 chk_out("rst_mid", 1'b0, 2'd0, 1'b0);
        rst = 1'b0;
        tick();
        chk_out("rst_after", 1'b1, 2'd0, 1'b0);

        // done with req drop together: single release, ptr=1.
        done = 1'b1;
        req  = 4'b0000;
        tick();
        chk_out("both_rel", 1'b0, 2'd0, 1'b0);
        // done in IDLE is ignored; grant proceeds from ptr=1 -> 3.
        req = 4'b1001;
        tick();
        done = 1'b0;
        chk_out("done_idle", 1'b1, 2'd3, 1'b0);
        req = 4'h0;
        tick();
        chk_out("final_idle", 1'b0, 2'd3, 1'b0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
